// File: rtl/cpu_pkg.sv
// Shared SimpRisc fetch types: entry struct, PC constants and the fetch FSM state encoding.
// The HALT state is only entered when fetch_unit is built with FETCH_MISALIGN_TRAP_EN.
package cpu_pkg;
  localparam int          ILEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem and decode: power-of-two depth, synchronous flush,
// and a head that holds its last value while the buffer is empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [ILEN-1:0]         push_pc,
  input  logic [ILEN-1:0]         push_inst,
  input  logic                    pop,
  output logic [ILEN-1:0]         head_pc,
  output logic [ILEN-1:0]         head_inst,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  hold;
  fetch_entry_t  head_ent;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  // When empty, the head mirrors the last entry decode saw (zero after reset).
  assign head_ent  = (count != '0) ? mem[rd_ptr] : hold;
  assign head_pc   = head_ent.pc;
  assign head_inst = head_ent.inst;
  assign do_pop    = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      hold <= head_ent;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// SimpRisc fetch stage: owns the PC, issues word requests to imem, buffers PC-tagged words for decode.
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises misalign_trap.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nreset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign_trap,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshakes: a transfer happens in a cycle where valid && ready at the rising edge;
  // valid never depends on ready of the same interface, imem responses are never stalled.
  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          epoch;
  logic          inflight_epoch;
  logic          outstanding;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          pop;
  logic          push;
  logic          accept;
  logic          redirect;
  logic [31:0]   target;

  assign redirect = redirect_valid && (state != BOOT);
  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign pop      = inst_valid && inst_ready;
  assign inst_valid = (fifo_count != '0);

  // Count buffered plus in-flight words so every accepted request has a guaranteed slot.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};
  assign imem_req_valid = (state == FETCH) && !redirect_valid &&
                          (occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Stale-epoch responses and responses colliding with a redirect are dropped.
  assign push = imem_rsp_valid && outstanding && (inflight_epoch == epoch) && !redirect;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= BOOT;
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      outstanding    <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap  <= 1'b0;
`endif
    end else begin
      outstanding <= accept;
      if (accept) begin
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
      end
      case (state)
        BOOT: state <= FETCH;
        FETCH, HALT: begin
          if (redirect) begin
            epoch    <= ~epoch;
            fetch_pc <= target;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
              state         <= HALT;
              misalign_trap <= 1'b1;
            end else begin
              state         <= FETCH;
              misalign_trap <= 1'b0;
            end
`endif
          end else if (accept) begin
            fetch_pc <= next_pc(fetch_pc);
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .flush     (redirect),
    .push      (push),
    .push_pc   (inflight_pc),
    .push_inst (imem_rsp_data),
    .pop       (pop),
    .head_pc   (inst_pc),
    .head_inst (inst_data),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table, redirect/wrap/trap/reset sequences,
// and a random run checked against an instruction-stream model (FETCH_MISALIGN_TRAP_EN aware).
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic mem_nop = 1'b1;
  logic [31:0] exp_q[$];

  logic        s_req_valid, s_inst_valid, s_trap;
  logic [31:0] s_req_addr, s_inst_pc, s_inst_data;

  typedef struct {
    logic        ir;
    logic        dr;
    logic        ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] epc;
    logic [31:0] edata;
  } vec_t;
  vec_t vt[21];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap  (misalign_trap),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_nop) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic vec_t mk(input logic ir, input logic dr, input logic ev, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] epc, input logic [31:0] edata);
    vec_t v;
    v.ir = ir; v.dr = dr; v.ev = ev; v.ea = ea; v.eiv = eiv; v.epc = epc; v.edata = edata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Inputs are set by the caller after a falling edge; outputs sampled 1ns later,
  // the imem model answers an accepted request during the following cycle.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    logic [31:0] e;
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    s_inst_data  = inst_data;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_trap = misalign_trap;
`else
    s_trap = 1'b0;
`endif
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (dut.push) check("push_into_full", {31'b0, dut.fifo_count == FIFO_DEPTH}, 32'd0);
    // scoreboard: decode must see a gapless sequential stream restarting at each redirect target
    if (inst_valid && inst_ready) begin
      pops++;
      e = exp_q.pop_front();
      check("sb_pc", inst_pc, e);
      check("sb_data", inst_data, mem_word(e));
      exp_q.push_back(e + 32'd4);
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
    end
    @(posedge clk);
    @(negedge clk);
    imem_rsp_valid = acc;
    imem_rsp_data  = acc ? mem_word(a) : $urandom();
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", inst_valid, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_trap", misalign_trap, 32'd0);
`endif
    #1;
    nreset = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
  endtask

  // Redirect in cycle N while streaming; target request at N+1, first instruction at N+3.
  task automatic redir_seq(input string tag, input logic [31:0] tgt, input logic [31:0] eff,
                           input logic n_iv, input logic [31:0] n_pc);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    cycle();
    redirect_valid = 1'b0;
    check({tag, "_n_req_valid"}, s_req_valid, 32'd0);
    check({tag, "_n_inst_valid"}, s_inst_valid, n_iv);
    if (n_iv) check({tag, "_n_inst_pc"}, s_inst_pc, n_pc);
    cycle();
    check({tag, "_n1_req_valid"}, s_req_valid, 32'd1);
    check({tag, "_n1_req_addr"}, s_req_addr, eff);
    check({tag, "_n1_inst_valid"}, s_inst_valid, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check({tag, "_n1_trap"}, s_trap, 32'd0);
`endif
    cycle();
    check({tag, "_n2_inst_valid"}, s_inst_valid, 32'd0);
    check({tag, "_n2_req_addr"}, s_req_addr, eff + 32'd4);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("%s_n%0d_inst_valid", tag, k + 3), s_inst_valid, 32'd1);
      check($sformatf("%s_n%0d_inst_pc", tag, k + 3), s_inst_pc, eff + 32'(4 * k));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int          rnd_pops;
    logic [31:0] rp;

    // cycle 0 is BOOT; columns: imem_ready, inst_ready, req_valid, req_addr, inst_valid, inst_pc, inst_data
    vt[0]  = mk(1, 1, 0, 32'd0,  0, 32'd0,  32'h0);
    vt[1]  = mk(1, 1, 1, 32'd0,  0, 32'd0,  32'h0);
    vt[2]  = mk(1, 1, 1, 32'd4,  0, 32'd0,  32'h0);
    vt[3]  = mk(1, 1, 1, 32'd8,  1, 32'd0,  32'h13);
    vt[4]  = mk(1, 1, 1, 32'd12, 1, 32'd4,  32'h13);
    vt[5]  = mk(1, 1, 1, 32'd16, 1, 32'd8,  32'h13);
    vt[6]  = mk(1, 1, 1, 32'd20, 1, 32'd12, 32'h13);
    for (int i = 7; i <= 16; i++) vt[i] = mk(1, 0, 0, 32'd24, 1, 32'd16, 32'h13);
    vt[17] = mk(1, 1, 1, 32'd24, 1, 32'd16, 32'h13);
    vt[18] = mk(1, 1, 1, 32'd28, 1, 32'd20, 32'h13);
    vt[19] = mk(1, 1, 1, 32'd32, 1, 32'd24, 32'h13);
    vt[20] = mk(1, 1, 1, 32'd36, 1, 32'd28, 32'h13);

    #2 nreset = 1'b0;
    @(negedge clk);
    mem_nop = 1'b1;
    do_reset();

    foreach (vt[i]) begin
      imem_req_ready = vt[i].ir;
      inst_ready     = vt[i].dr;
      cycle();
      check($sformatf("v%0d_req_valid", i), s_req_valid, vt[i].ev);
      check($sformatf("v%0d_req_addr", i), s_req_addr, vt[i].ea);
      check($sformatf("v%0d_inst_valid", i), s_inst_valid, vt[i].eiv);
      check($sformatf("v%0d_inst_pc", i), s_inst_pc, vt[i].epc);
      check($sformatf("v%0d_inst_data", i), s_inst_data, vt[i].edata);
    end

    // redirect while the word at 0x8 is in flight, then PC wrap at the top of memory
    do_reset();
    mem_nop = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    redir_seq("r100", 32'h0000_0100, 32'h0000_0100, 1'b1, 32'h4);
    redir_seq("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1, 32'h0000_010C);

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    cycle();
    redirect_valid = 1'b0;
    check("trap_n", s_trap, 32'd0);
    check("trap_n_req_valid", s_req_valid, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("trap_set", s_trap, 32'd1);
      check("trap_req_valid", s_req_valid, 32'd0);
      check("trap_inst_valid", s_inst_valid, 32'd0);
    end
    redir_seq("halt_exit", 32'h0000_0200, 32'h0000_0200, 1'b0, 32'h0);
`else
    redir_seq("mis", 32'h0000_0102, 32'h0000_0100, 1'b1, 32'h4);
`endif

    // reset mid-stream: the pending imem response must be ignored
    do_reset();
    cycle();
    check("rr0_req_valid", s_req_valid, 32'd0);
    check("rr0_inst_valid", s_inst_valid, 32'd0);
    cycle();
    check("rr1_req_valid", s_req_valid, 32'd1);
    check("rr1_req_addr", s_req_addr, RESET_PC);
    check("rr1_inst_valid", s_inst_valid, 32'd0);
    cycle();
    check("rr2_inst_valid", s_inst_valid, 32'd0);
    cycle();
    check("rr3_inst_valid", s_inst_valid, 32'd1);
    check("rr3_inst_pc", s_inst_pc, RESET_PC);

    // random run: backpressure on both sides plus occasional redirects
    rnd_pops = pops;
    for (int n = 0; n < 3000; n++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      rp = $urandom();
      if ($urandom_range(0, 4) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
      rp[1:0] = 2'b00;
`endif
      redirect_pc = rp;
      cycle();
      if (s_req_valid) check("rnd_req_aligned", {30'b0, s_req_addr[1:0]}, 32'd0);
    end
    redirect_valid = 1'b0;
    check("rnd_progress", {31'b0, (pops - rnd_pops) >= 300}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
